input_periph: RTL and testbench
===============================

Name: input_periph

Overview:
Parametrised successor to the memory-mapped switch/button input buffer, sitting on the LSU load/store path at region 16'h7800-16'h781F.
- Adds 2-flop synchronisers on all inputs and per-button debounce.
- Adds sticky rising-edge capture registers, cleared by a store (write-1-to-clear).
- Read data is combinational from registered state, so single-cycle loads still work.

Parameters:
- NUM_SW, 32, switch inputs (1..32).
- NUM_BTN, 4, button inputs (1..16).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a button level is accepted (>=2).
- BASE_ADDR, 16'h7800, region base; region is BASE_ADDR..BASE_ADDR+16'h1F.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_lsu_addr  in  16  byte address
- i_funct3  in  3  load/store size code
- i_wr_en  in  1  store strobe
- i_wr_data  in  32  store data
- i_io_sw  in  NUM_SW  raw switches
- i_io_btn  in  NUM_BTN  raw buttons, active-high
- o_rd_data  out  32  load data, sign/zero-extended
- o_hit  out  1  address is inside the region
- o_irq  out  1  interrupt request (optional feature)

Behaviour:
- Interface: one clock i_clk; reset i_rst_n is asynchronous, active-low. Reset clears all synchroniser flops, debounce counters, stable levels, the edge register and the mask register to 0; o_irq = 0.
- Word map (offset from BASE_ADDR; unused bits read 0):
  - 0x00: SW[NUM_SW-1:0], synchronised only.
  - 0x10: BTN_LEVEL, debounced.
  - 0x14: BTN_EDGE, sticky, W1C.
  - 0x18: IRQ_MASK.
  - All other offsets read 0.
- Synchroniser: 2 flops per bit. A switch change is readable 2 cycles after the input edge.
- Debounce, per button:
  - While sync == stable, counter = 0.
  - While sync != stable, counter increments each cycle.
  - On the edge where counter == DEBOUNCE_CYCLES-1 and the mismatch persists: stable <= sync, counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
  - Total latency from raw edge to BTN_LEVEL = 2 + DEBOUNCE_CYCLES cycles.
- Edge capture: BTN_EDGE[i] is set in the same cycle stable[i] rises 0->1; falls are ignored.
- Edge clear: a store with i_wr_en=1, o_hit=1, i_funct3=3'b010 to offset 0x14 clears every bit where i_wr_data is 1. A set and a clear of the same bit in one cycle leave the bit set.
- Store scope:
  - Only funct3=010 stores are honoured, at 0x14 and 0x18. All other stores are ignored with no side effect.
  - Stores to 0x00/0x10 are ignored.
- Loads (combinational):
  - funct3 000/100: byte at addr[4:0], sign-/zero-extended.
  - funct3 001/101: halfword at addr & ~1, sign-/zero-extended.
  - funct3 010: word at addr & ~3.
  - Little-endian byte lanes.
  - Any other funct3 returns 0.
- Out of region: o_hit = 0 and o_rd_data = 32'h0. Never drive Z; the bus mux selects on o_hit.
- Reset mid-debounce: counters and levels return to 0; no edge is recorded.
- Width rules:
  - Counter width = $clog2(DEBOUNCE_CYCLES).
  - SW and BTN are zero-padded to 32 bits; NUM_SW < 32 leaves the upper bits 0.

Optional Feature:
- INPUT_PERIPH_IRQ_EN defined:
  - IRQ_MASK[NUM_BTN-1:0] is writable at 0x18 (funct3 010 store).
  - o_irq is registered: o_irq <= |(BTN_EDGE & IRQ_MASK), one cycle after the edge bit sets or clears.
- Undefined:
  - No mask register; 0x18 reads 0; stores to it are ignored.
  - o_irq is tied to 0.

Decomposition:
- Package input_periph_pkg:
  - Offset constants OFF_SW, OFF_BTN_LEVEL, OFF_BTN_EDGE, OFF_IRQ_MASK.
  - funct3 enum: LB, LH, LW, LBU, LHU, SW.
  - Region size constant 16'h20.
- Sub-module btn_debounce: one instance per button via generate. Contains the synchroniser, counter and stable level; outputs o_level and a single-cycle o_rise pulse.
- Top level holds the switch synchronisers, edge/mask registers, read mux and extension.

Test Plan:
- Reset, then i_io_sw=32'hDEAD_BEEF for 3 cycles; LW at 16'h7800 -> 32'hDEADBEEF, o_hit=1. LB at 16'h7803 -> 32'hFFFFFFDE. LBU at 16'h7801 -> 32'h000000BE.
- btn[0] pulses high for 10 cycles (DEBOUNCE_CYCLES=16) -> BTN_LEVEL stays 0 and BTN_EDGE stays 0.
- btn[2] held high -> BTN_LEVEL reads 32'h4 exactly 18 cycles after the raw edge, and BTN_EDGE reads 32'h4. After release for 18 cycles, BTN_LEVEL=0 and BTN_EDGE is still 4.
- SW of 32'h4 to 16'h7814 -> BTN_EDGE=0. A new btn[2] rise coinciding with a W1C of bit 2 -> bit stays 1.
- LW at 16'h7820 and at 16'h77FC -> o_hit=0, o_rd_data=0. SB to 16'h7814 -> BTN_EDGE unchanged.
- With INPUT_PERIPH_IRQ_EN: SW 32'h1 to 16'h7818, btn[0] rise -> o_irq=1 one cycle after BTN_EDGE[0] sets. W1C of bit 0 -> o_irq=0 one cycle later. Assert i_rst_n low mid-count -> all reads 0, o_irq=0.

Source files
------------

// File: rtl/input_periph_pkg.sv
// Shared definitions for the memory-mapped input peripheral:
// register offsets inside the 32-byte region, region size and LSU size codes.
package input_periph_pkg;

  localparam logic [4:0] OFF_SW        = 5'h00;
  localparam logic [4:0] OFF_BTN_LEVEL = 5'h10;
  localparam logic [4:0] OFF_BTN_EDGE  = 5'h14;
  localparam logic [4:0] OFF_IRQ_MASK  = 5'h18;

  localparam logic [15:0] REGION_SIZE = 16'h20;

  // Load size codes; the unsigned variants set bit 2.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  // Store size codes; only full-word stores change peripheral state.
  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_e;

endpackage

// File: rtl/input_periph_btn_debounce.sv
// One button: 2-flop synchroniser, mismatch counter and accepted level.
// The level only changes after the synchronised input has disagreed with it
// for DEBOUNCE_CYCLES consecutive cycles; o_rise marks the cycle it goes 0->1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  // The counter has already seen DEBOUNCE_CYCLES-1 mismatching cycles and
  // this one mismatches too, so the new level is taken on this edge.
  assign accept = (sync_q[1] != stable_q) && (cnt_q == CNT_MAX);

  // Synchronise the raw input and count how long it has differed from the level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q <= {sync_q[0], i_btn};
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_level = stable_q;
  assign o_rise  = accept && sync_q[1];

endmodule

// File: rtl/input_periph.sv
// Memory-mapped switch/button input block on the LSU path.
// Switches are synchronised, buttons debounced, button rises are held in a
// write-1-to-clear register. Loads are combinational from registered state.
// Define INPUT_PERIPH_IRQ_EN to add the writable IRQ mask and registered o_irq.
module input_periph
  import input_periph_pkg::*;
#(
  parameter int          NUM_SW          = 32,
  parameter int          NUM_BTN         = 4,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [15:0] BASE_ADDR       = 16'h7800
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [15:0]         i_lsu_addr,
  input  logic [2:0]          i_funct3,
  input  logic                i_wr_en,
  input  logic [31:0]         i_wr_data,
  input  logic [NUM_SW-1:0]   i_io_sw,
  input  logic [NUM_BTN-1:0]  i_io_btn,
  output logic [31:0]         o_rd_data,
  output logic                o_hit,
  output logic                o_irq
);

  logic [15:0]        offset;
  logic [4:0]         off;
  logic [NUM_SW-1:0]  sw_meta_q;
  logic [NUM_SW-1:0]  sw_sync_q;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] edge_q;
  logic [NUM_BTN-1:0] edge_clr;
  logic [NUM_BTN-1:0] mask_val;
  logic               wr_word;
  logic [31:0]        word;
  logic [31:0]        shift_b;
  logic [31:0]        shift_h;
  logic               unused_bits;

  // Addresses below the base wrap to large offsets, so one compare covers both ends.
  assign offset = i_lsu_addr - BASE_ADDR;
  assign o_hit  = (offset < REGION_SIZE);
  assign off    = offset[4:0];

  assign wr_word  = i_wr_en && o_hit && (i_funct3 == SW);
  assign edge_clr = (wr_word && (off == OFF_BTN_EDGE)) ? i_wr_data[NUM_BTN-1:0] : '0;

  // Two-flop synchroniser for every switch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= i_io_sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_btn   (i_io_btn[g]),
      .o_level (btn_level[g]),
      .o_rise  (btn_rise[g])
    );
  end

  // Sticky rise capture; a new rise wins over a clear of the same bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      edge_q <= '0;
    end else begin
      edge_q <= (edge_q & ~edge_clr) | btn_rise;
    end
  end

`ifdef INPUT_PERIPH_IRQ_EN
  logic [NUM_BTN-1:0] mask_q;
  logic               irq_q;

  // Mask register written by word stores; irq follows the masked edges one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_word && (off == OFF_IRQ_MASK)) begin
        mask_q <= i_wr_data[NUM_BTN-1:0];
      end
      irq_q <= |(edge_q & mask_q);
    end
  end

  assign mask_val = mask_q;
  assign o_irq    = irq_q;
`else
  assign mask_val = '0;
  assign o_irq    = 1'b0;
`endif

  // Select the addressed word, then extract and extend the requested lane.
  always_comb begin
    word = 32'h0;
    case ({off[4:2], 2'b00})
      OFF_SW:        word = 32'(sw_sync_q);
      OFF_BTN_LEVEL: word = 32'(btn_level);
      OFF_BTN_EDGE:  word = 32'(edge_q);
      OFF_IRQ_MASK:  word = 32'(mask_val);
      default:       word = 32'h0;
    endcase

    shift_b = word >> {off[1:0], 3'b000};
    shift_h = word >> {off[1], 4'b0000};

    o_rd_data = 32'h0;
    case (i_funct3)
      LB:      o_rd_data = {{24{shift_b[7]}}, shift_b[7:0]};
      LBU:     o_rd_data = {24'h0, shift_b[7:0]};
      LH:      o_rd_data = {{16{shift_h[15]}}, shift_h[15:0]};
      LHU:     o_rd_data = {16'h0, shift_h[15:0]};
      LW:      o_rd_data = word;
      default: o_rd_data = 32'h0;
    endcase

    if (!o_hit) begin
      o_rd_data = 32'h0;
    end
  end

  assign unused_bits = ^{i_wr_data, shift_b[31:8], shift_h[31:16]};

endmodule

// File: tb/tb_input_periph.sv
// Self-checking bench for input_periph: directed walk through the main
// behaviours followed by randomized traffic compared with a reference model
// that judges debounce from a window of recent samples.
module tb_input_periph;

  localparam int NB = 4;
  localparam int DB = 16;
  localparam int HL = DB + 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] lsu_addr;
  logic [2:0]  funct3;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] io_sw;
  logic [NB-1:0] io_btn;
  logic [31:0] rd_data;
  logic        hit;
  logic        irq;

  int n_compared = 0;
  int n_mismatched = 0;

  input_periph #(
    .NUM_SW(32), .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .BASE_ADDR(16'h7800)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_lsu_addr (lsu_addr),
    .i_funct3   (funct3),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .i_io_sw    (io_sw),
    .i_io_btn   (io_btn),
    .o_rd_data  (rd_data),
    .o_hit      (hit),
    .o_irq      (irq)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [31:0]   m_sw0, m_sw1;
  logic [NB-1:0] m_level, m_edge, m_mask;
  logic          m_irq;
  logic [HL-1:0] m_hist [NB];
  logic [HL-1:0] n_hist [NB];
  logic [NB-1:0] n_level, n_rise, n_clr;

  // A level flips once the synchronised value (2 samples back) has disagreed
  // with it for DB samples in a row.
  function automatic logic window_flips(logic [HL-1:0] h, logic lv);
    for (int k = 2; k < HL; k++) begin
      if (h[k] == lv) return 1'b0;
    end
    return 1'b1;
  endfunction

  always_comb begin
    n_level = m_level;
    n_rise  = '0;
    for (int b = 0; b < NB; b++) begin
      n_hist[b] = {m_hist[b][HL-2:0], io_btn[b]};
      if (window_flips(n_hist[b], m_level[b])) begin
        n_level[b] = ~m_level[b];
        n_rise[b]  = ~m_level[b];
      end
    end
    n_clr = (wr_en && funct3 == 3'b010 && lsu_addr == 16'h7814) ? wr_data[NB-1:0] : '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sw0 <= '0; m_sw1 <= '0;
      m_level <= '0; m_edge <= '0; m_mask <= '0; m_irq <= 1'b0;
      for (int b = 0; b < NB; b++) m_hist[b] <= '0;
    end else begin
      m_sw0 <= io_sw;
      m_sw1 <= m_sw0;
      for (int b = 0; b < NB; b++) m_hist[b] <= n_hist[b];
      m_level <= n_level;
      m_edge  <= (m_edge & ~n_clr) | n_rise;
`ifdef INPUT_PERIPH_IRQ_EN
      m_irq <= |(m_edge & m_mask);
      if (wr_en && funct3 == 3'b010 && lsu_addr == 16'h7818) m_mask <= wr_data[NB-1:0];
`endif
    end
  end

  function automatic logic [31:0] model_word(int off);
    case (off)
      0:  return m_sw1;
      16: return 32'(m_level);
      20: return 32'(m_edge);
      24: return 32'(m_mask);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(logic [15:0] addr, logic [2:0] f3);
    int off;
    logic [31:0] b, h;
    if (addr < 16'h7800 || addr > 16'h781F) return 32'h0;
    off = int'(addr) - 'h7800;
    b = (model_word(off - off % 4) >> (8 * (off % 4))) & 32'hFF;
    h = (model_word(off - off % 4) >> (8 * (off % 4 - off % 2))) & 32'hFFFF;
    case (f3)
      3'b000: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b100: return b;
      3'b001: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b101: return h;
      3'b010: return model_word(off - off % 4);
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] sw, input logic [NB-1:0] btn,
                               input logic we, input logic [15:0] addr,
                               input logic [2:0] f3, input logic [31:0] data);
    io_sw = sw; io_btn = btn; wr_en = we; lsu_addr = addr; funct3 = f3; wr_data = data;
  endtask

  task automatic doStore(input logic [15:0] addr, input logic [2:0] f3, input logic [31:0] data);
    wr_en = 1'b1; lsu_addr = addr; funct3 = f3; wr_data = data;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic checkConst(input string tag, input logic [15:0] addr, input logic [2:0] f3,
                            input logic [31:0] exp_data, input logic exp_hit);
    lsu_addr = addr; funct3 = f3;
    #1;
    checkOutput({tag, "_data"}, rd_data, exp_data);
    checkOutput({tag, "_hit"}, 32'(hit), 32'(exp_hit));
  endtask

  task automatic checkModel(input string tag, input logic [15:0] addr, input logic [2:0] f3);
    lsu_addr = addr; funct3 = f3;
    #1;
    checkOutput({tag, "_data"}, rd_data, model_read(addr, f3));
    checkOutput({tag, "_hit"}, 32'(hit), 32'(addr >= 16'h7800 && addr <= 16'h781F));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] addr_tbl [6];
    addr_tbl[0] = 16'h7814; addr_tbl[1] = 16'h7818; addr_tbl[2] = 16'h7810;
    addr_tbl[3] = 16'h7800; addr_tbl[4] = 16'h7815; addr_tbl[5] = 16'h7820;

    rst_n = 1'b0;
    applyStimulus(32'h0, '0, 1'b0, 16'h7800, 3'b010, 32'h0);
    tick(2);
    checkConst("rst_sw", 16'h7800, 3'b010, 32'h0, 1'b1);
    checkConst("rst_lvl", 16'h7810, 3'b010, 32'h0, 1'b1);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;

    // Switch word and byte lanes
    io_sw = 32'hDEAD_BEEF;
    tick(3);
    checkConst("sw_lw", 16'h7800, 3'b010, 32'hDEAD_BEEF, 1'b1);
    checkConst("sw_lb", 16'h7803, 3'b000, 32'hFFFF_FFDE, 1'b1);
    checkConst("sw_lbu", 16'h7801, 3'b100, 32'h0000_00BE, 1'b1);
    checkConst("sw_lh", 16'h7802, 3'b001, 32'hFFFF_DEAD, 1'b1);

    // Short glitch on btn[0]
    io_btn = 4'b0001; tick(10);
    io_btn = 4'b0000; tick(20);
    checkConst("glitch_lvl", 16'h7810, 3'b010, 32'h0, 1'b1);
    checkConst("glitch_edge", 16'h7814, 3'b010, 32'h0, 1'b1);

    // btn[2] held: level appears exactly 18 cycles after the raw edge
    io_btn = 4'b0100; tick(17);
    checkConst("lvl_17", 16'h7810, 3'b010, 32'h0, 1'b1);
    tick(1);
    checkConst("lvl_18", 16'h7810, 3'b010, 32'h4, 1'b1);
    checkConst("edge_18", 16'h7814, 3'b010, 32'h4, 1'b1);
    io_btn = 4'b0000; tick(18);
    checkConst("rel_lvl", 16'h7810, 3'b010, 32'h0, 1'b1);
    checkConst("rel_edge", 16'h7814, 3'b010, 32'h4, 1'b1);

    // W1C, then a clear colliding with a new rise
    doStore(16'h7814, 3'b010, 32'h4);
    checkConst("w1c", 16'h7814, 3'b010, 32'h0, 1'b1);
    io_btn = 4'b0100; tick(17);
    doStore(16'h7814, 3'b010, 32'h4);
    checkConst("w1c_race", 16'h7814, 3'b010, 32'h4, 1'b1);

    // Out of region and ignored stores
    checkConst("oor_hi", 16'h7820, 3'b010, 32'h0, 1'b0);
    checkConst("oor_lo", 16'h77FC, 3'b010, 32'h0, 1'b0);
    doStore(16'h7814, 3'b000, 32'hFF);
    checkConst("sb_ign", 16'h7814, 3'b010, 32'h4, 1'b1);
    doStore(16'h7810, 3'b010, 32'hFFFF_FFFF);
    checkConst("lvl_ro", 16'h7810, 3'b010, 32'h4, 1'b1);

    io_btn = 4'b0000; tick(20);
    doStore(16'h7814, 3'b010, 32'hF);
    checkConst("edge_clr_all", 16'h7814, 3'b010, 32'h0, 1'b1);
`ifdef INPUT_PERIPH_IRQ_EN
    doStore(16'h7818, 3'b010, 32'h1);
    checkConst("mask_rd", 16'h7818, 3'b010, 32'h1, 1'b1);
    io_btn = 4'b0001; tick(18);
    checkConst("irq_edge", 16'h7814, 3'b010, 32'h1, 1'b1);
    checkOutput("irq_lag", 32'(irq), 32'h0);
    tick(1);
    checkOutput("irq_set", 32'(irq), 32'h1);
    doStore(16'h7814, 3'b010, 32'h1);
    checkOutput("irq_hold", 32'(irq), 32'h1);
    tick(1);
    checkOutput("irq_clr", 32'(irq), 32'h0);
    io_btn = 4'b0000;
`else
    doStore(16'h7818, 3'b010, 32'h1);
    checkConst("mask_absent", 16'h7818, 3'b010, 32'h0, 1'b1);
    checkOutput("irq_tied", 32'(irq), 32'h0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [NB-1:0] flip;
      logic [15:0]   ra;
      flip = '0;
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 19) == 0) flip[b] = 1'b1;
      ra = 16'($urandom_range(16'h77F8, 16'h7827));
      if ($urandom_range(0, 5) == 0) begin
        logic [2:0] sf;
        sf = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 1)) : 3'b010;
        applyStimulus($urandom, io_btn ^ flip, 1'b1, addr_tbl[$urandom_range(0, 5)], sf, $urandom);
      end else begin
        applyStimulus($urandom, io_btn ^ flip, 1'b0, ra, 3'($urandom_range(0, 7)), 32'h0);
      end
      #1;
      checkOutput("rnd_data", rd_data, model_read(lsu_addr, funct3));
      checkOutput("rnd_hit", 32'(hit), 32'(lsu_addr >= 16'h7800 && lsu_addr <= 16'h781F));
      checkOutput("rnd_irq", 32'(irq), 32'(m_irq));
      tick(1);
    end
    wr_en = 1'b0;
    checkModel("post_lvl", 16'h7810, 3'b010);
    checkModel("post_edge", 16'h7814, 3'b010);
    checkModel("post_mask", 16'h7818, 3'b010);

    // Reset in the middle of a debounce count
    io_btn = 4'b0000; tick(25);
    io_btn = 4'b0010; tick(8);
    #2 rst_n = 1'b0;
    checkConst("mid_rst_sw", 16'h7800, 3'b010, 32'h0, 1'b1);
    checkConst("mid_rst_lvl", 16'h7810, 3'b010, 32'h0, 1'b1);
    checkConst("mid_rst_edge", 16'h7814, 3'b010, 32'h0, 1'b1);
    checkConst("mid_rst_mask", 16'h7818, 3'b010, 32'h0, 1'b1);
    checkOutput("mid_rst_irq", 32'(irq), 32'h0);
    tick(2);
    io_btn = 4'b0000;
    rst_n = 1'b1;
    tick(25);
    checkConst("after_rst_lvl", 16'h7810, 3'b010, 32'h0, 1'b1);
    checkConst("after_rst_edge", 16'h7814, 3'b010, 32'h0, 1'b1);
    checkOutput("after_rst_irq", 32'(irq), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
